// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game controller.
// Cell n of the board is bit n of ain/bin.
package ttt_pkg;

  localparam int unsigned CELLS = 9;
  localparam int unsigned POS_W = 4;
  localparam int unsigned LINES = 8;
  localparam int unsigned CNT_W = 4;

  localparam logic [CELLS-1:0] FULL_BOARD = 9'h1FF;
  localparam logic [POS_W-1:0] LAST_CELL  = 4'd8;

  typedef enum logic [1:0] {
    PLAY_A = 2'd0,
    PLAY_B = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    W_NONE = 2'b00,
    W_A    = 2'b01,
    W_B    = 2'b10,
    W_DRAW = 2'b11
  } winner_e;

  // One-hot mask of a cell; out-of-range positions map to an empty mask.
  function automatic logic [CELLS-1:0] cell_mask(input logic [POS_W-1:0] pos);
    return (pos <= LAST_CELL) ? (CELLS'(1) << pos) : '0;
  endfunction

endpackage

// File: rtl/ttt_game_ctrl_if.sv
// Move handshake between the input stage (master) and the game controller (slave).
interface ttt_game_ctrl_if;

  logic                       new_game;
  logic                       move_valid;
  logic [ttt_pkg::POS_W-1:0]  move_pos;
  logic                       move_ready;

  modport master (
    output new_game,
    output move_valid,
    output move_pos,
    input  move_ready
  );

  modport slave (
    input  new_game,
    input  move_valid,
    input  move_pos,
    output move_ready
  );

endinterface

// File: rtl/DetectWinner.sv
// Combinational three-in-a-row detector over both players' boards.
// Bits: [0] row 6-8, [1] row 3-5, [2] row 0-2, [3..5] columns 0/1/2, [6] diag 0-4-8, [7] diag 2-4-6.
module DetectWinner
  import ttt_pkg::*;
(
  input  logic [CELLS-1:0] ain,
  input  logic [CELLS-1:0] bin,
  output logic [LINES-1:0] win_line
);

  function automatic logic [LINES-1:0] lines_of(input logic [CELLS-1:0] b);
    return {b[2] & b[4] & b[6],
            b[0] & b[4] & b[8],
            b[2] & b[5] & b[8],
            b[1] & b[4] & b[7],
            b[0] & b[3] & b[6],
            b[0] & b[1] & b[2],
            b[3] & b[4] & b[5],
            b[6] & b[7] & b[8]};
  endfunction

  assign win_line = lines_of(ain) | lines_of(bin);

endmodule

// File: rtl/ttt_turn_timer.sv
// Per-turn idle counter; expired flags the last allowed idle cycle.
// A TIMEOUT_CYCLES of zero never expires.
module ttt_turn_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TMR_W          = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TMR_W'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) &&
                   (count == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: owns the board, alternates turns, judges the
// result from an external DetectWinner, and forfeits a player on turn timeout.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int unsigned FIRST_PLAYER   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TMR_W          = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  ttt_game_ctrl_if.slave      bus,
  input  logic [LINES-1:0]    win_line,
  output logic [CELLS-1:0]    ain,
  output logic [CELLS-1:0]    bin,
  output logic                turn,
  output logic                illegal,
  output logic                game_over,
  output logic [1:0]          winner,
  output logic [LINES-1:0]    win_line_q,
  output logic [CNT_W-1:0]    move_cnt
);

  localparam state_e START_STATE = (FIRST_PLAYER != 0) ? PLAY_B : PLAY_A;
  localparam logic   START_TURN  = (FIRST_PLAYER != 0);

  state_e            state_q, state_d;
  logic [CELLS-1:0]  ain_d, bin_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [1:0]        winner_d;
  logic [LINES-1:0]  wlq_d;
  logic              illegal_d;
  logic              last_q, last_d;

  logic              in_play;
  logic              mover_b;
  logic              move_hs;
  logic              move_legal;
  logic              tmr_clear;
  logic              tmr_expired;
  logic [CELLS-1:0]  occupied;
  logic [CELLS-1:0]  pos_mask;

  assign in_play    = (state_q == PLAY_A) || (state_q == PLAY_B);
  assign mover_b    = (state_q == PLAY_B);
  assign move_hs    = in_play && bus.move_valid;
  assign occupied   = ain | bin;
  assign pos_mask   = cell_mask(bus.move_pos);
  assign move_legal = (bus.move_pos <= LAST_CELL) && ((occupied & pos_mask) == '0);

  ttt_turn_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .enable  (in_play),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= START_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and board/result updates; new_game overrides everything.
  always_comb begin
    state_d   = state_q;
    ain_d     = ain;
    bin_d     = bin;
    cnt_d     = move_cnt;
    winner_d  = winner;
    wlq_d     = win_line_q;
    last_d    = last_q;
    illegal_d = 1'b0;
    tmr_clear = !in_play;

    if (bus.new_game) begin
      state_d   = START_STATE;
      ain_d     = '0;
      bin_d     = '0;
      cnt_d     = '0;
      winner_d  = W_NONE;
      wlq_d     = '0;
      last_d    = 1'b0;
      tmr_clear = 1'b1;
    end else begin
      unique case (state_q)
        PLAY_A, PLAY_B: begin
          if (move_hs && move_legal) begin
            if (mover_b) begin
              bin_d = bin | pos_mask;
            end else begin
              ain_d = ain | pos_mask;
            end
            cnt_d     = move_cnt + CNT_W'(1);
            last_d    = mover_b;
            tmr_clear = 1'b1;
            state_d   = CHECK;
          end else begin
            illegal_d = move_hs;
            // Illegal attempts keep the clock running toward forfeit.
            if (tmr_expired) begin
              state_d  = DONE;
              winner_d = mover_b ? W_A : W_B;
              wlq_d    = '0;
            end
          end
        end
        CHECK: begin
          if (win_line != '0) begin
            state_d  = DONE;
            winner_d = last_q ? W_B : W_A;
            wlq_d    = win_line;
          end else if (occupied == FULL_BOARD) begin
            state_d  = DONE;
            winner_d = W_DRAW;
          end else begin
            state_d  = last_q ? PLAY_A : PLAY_B;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = START_STATE;
        end
      endcase
    end
  end

  // Registered outputs, decoded from the next state where they reflect it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ain            <= '0;
      bin            <= '0;
      move_cnt       <= '0;
      winner         <= W_NONE;
      win_line_q     <= '0;
      illegal        <= 1'b0;
      last_q         <= 1'b0;
      game_over      <= 1'b0;
      turn           <= START_TURN;
      bus.move_ready <= 1'b1;
    end else begin
      ain            <= ain_d;
      bin            <= bin_d;
      move_cnt       <= cnt_d;
      winner         <= winner_d;
      win_line_q     <= wlq_d;
      illegal        <= illegal_d;
      last_q         <= last_d;
      game_over      <= (state_d == DONE);
      bus.move_ready <= (state_d == PLAY_A) || (state_d == PLAY_B);
      if (state_d == PLAY_A) begin
        turn <= 1'b0;
      end else if (state_d == PLAY_B) begin
        turn <= 1'b1;
      end
    end
  end

  a_board_disjoint: assert property (@(posedge clk) disable iff (!rst_n) (ain & bin) == '0);

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Scoreboard bench for ttt_game_ctrl + DetectWinner: a game model predicts every
// visible output change, a monitor compares whenever the DUT outputs change.
module tb_ttt_game_ctrl;
  import ttt_pkg::*;

  localparam int TMO = 5;
  localparam int PH_PLAY = 0, PH_CHECK = 1, PH_DONE = 2;

  typedef struct packed {
    logic [8:0] ain;
    logic [8:0] bin;
    logic [3:0] cnt;
    logic       ill;
    logic       over;
    logic       ready;
    logic       turn;
    logic [1:0] win;
    logic [7:0] wlq;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] win_line, win_line_q;
  logic [8:0] ain, bin;
  logic       turn, illegal, game_over;
  logic [1:0] winner;
  logic [3:0] move_cnt;

  always #5 clk = ~clk;

  ttt_game_ctrl_if bus();

  ttt_game_ctrl #(.FIRST_PLAYER(0), .TIMEOUT_CYCLES(TMO), .TMR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .win_line(win_line),
    .ain(ain), .bin(bin), .turn(turn), .illegal(illegal), .game_over(game_over),
    .winner(winner), .win_line_q(win_line_q), .move_cnt(move_cnt)
  );

  DetectWinner u_dw (.ain(ain), .bin(bin), .win_line(win_line));

  int n_cmp = 0;
  int n_bad = 0;
  obs_t exp_q[$];
  obs_t last_o;

  // Reference game: cell arrays per player, win lines listed as cell triples.
  int lines [8][3] = '{'{6,7,8}, '{3,4,5}, '{0,1,2}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int a [9];
  int b [9];
  int ph, mover, last, cnt, tmr, win, ill;
  logic [7:0] wlq;

  function automatic logic [7:0] lines_hit();
    logic [7:0] m = '0;
    for (int l = 0; l < 8; l++) begin
      if ((a[lines[l][0]] != 0 && a[lines[l][1]] != 0 && a[lines[l][2]] != 0) ||
          (b[lines[l][0]] != 0 && b[lines[l][1]] != 0 && b[lines[l][2]] != 0))
        m |= 8'(1) << l;
    end
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin a[i] = 0; b[i] = 0; end
    ph = PH_PLAY; mover = 0; last = 0; cnt = 0; tmr = 0; win = 0; ill = 0; wlq = '0;
  endtask

  task automatic model_step(input bit ng, input bit mv, input int pos);
    bit accepted;
    logic [7:0] hit;
    if (ng) begin
      model_reset();
      return;
    end
    ill = 0;
    accepted = 0;
    case (ph)
      PH_PLAY: begin
        if (mv) begin
          if (pos <= 8 && a[pos] == 0 && b[pos] == 0) begin
            if (mover == 0) a[pos] = 1; else b[pos] = 1;
            cnt++; last = mover; tmr = 0; ph = PH_CHECK; accepted = 1;
          end else begin
            ill = 1;
          end
        end
        if (!accepted) begin
          if (TMO != 0 && tmr == TMO - 1) begin
            ph = PH_DONE; win = (mover == 0) ? 2 : 1; wlq = '0;
          end else begin
            tmr++;
          end
        end
      end
      PH_CHECK: begin
        hit = lines_hit();
        if (hit != 0) begin
          ph = PH_DONE; win = last + 1; wlq = hit;
        end else if (cnt == 9) begin
          ph = PH_DONE; win = 3;
        end else begin
          ph = PH_PLAY; mover = 1 - last; tmr = 0;
        end
      end
      default: ;
    endcase
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o = '0;
    for (int i = 0; i < 9; i++) begin
      if (a[i] != 0) o.ain |= 9'(1) << i;
      if (b[i] != 0) o.bin |= 9'(1) << i;
    end
    o.cnt   = 4'(cnt);
    o.ill   = (ill != 0);
    o.over  = (ph == PH_DONE);
    o.ready = (ph == PH_PLAY);
    o.turn  = o.ready && (mover != 0);
    o.win   = 2'(win);
    o.wlq   = wlq;
    return o;
  endfunction

  task automatic push_obs(input bit force_push);
    obs_t o;
    o = model_obs();
    if (force_push || o != last_o || o.ill) exp_q.push_back(o);
    last_o = o;
  endtask

  function automatic obs_t dut_obs();
    obs_t s;
    s.ain = ain; s.bin = bin; s.cnt = move_cnt; s.ill = illegal;
    s.over = game_over; s.ready = bus.move_ready; s.turn = bus.move_ready & turn;
    s.win = winner; s.wlq = win_line_q;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Called at a falling edge: apply inputs for the next rising edge.
  task automatic drive(input bit ng, input bit mv, input int pos);
    bus.new_game = ng; bus.move_valid = mv; bus.move_pos = 4'(pos);
    model_step(ng, mv, pos);
    push_obs(1'b0);
    @(negedge clk);
  endtask

  task automatic play(input int pos);
    drive(0, 1, pos);
    drive(0, 0, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    bus.new_game = 1'b0; bus.move_valid = 1'b0;
    model_reset();
    push_obs(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one comparison each time the visible outputs change (or illegal pulses).
  initial begin
    obs_t s, e, prev;
    bit first;
    first = 1'b1;
    prev = '0;
    forever begin
      @(posedge clk); #1;
      s = dut_obs();
      if (first || s != prev || s.ill) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard: unexpected output ain=%h bin=%h cnt=%0d ill=%b over=%b rdy=%b turn=%b win=%0d wlq=%h",
                   s.ain, s.bin, s.cnt, s.ill, s.over, s.ready, s.turn, s.win, s.wlq);
        end else begin
          e = exp_q.pop_front();
          if (s !== e) begin
            n_bad++;
            $display("FAIL scoreboard: got ain=%h bin=%h cnt=%0d ill=%b over=%b rdy=%b turn=%b win=%0d wlq=%h expected ain=%h bin=%h cnt=%0d ill=%b over=%b rdy=%b turn=%b win=%0d wlq=%h",
                     s.ain, s.bin, s.cnt, s.ill, s.over, s.ready, s.turn, s.win, s.wlq,
                     e.ain, e.bin, e.cnt, e.ill, e.over, e.ready, e.turn, e.win, e.wlq);
          end
        end
      end
      first = 1'b0;
      prev = s;
    end
  end

  initial begin
    int r, pos;
    bit ng, mv;
    bus.new_game = 1'b0; bus.move_valid = 1'b0; bus.move_pos = '0;
    model_reset();
    push_obs(1'b1);
    repeat (2) @(negedge clk);
    chk("reset_board", {ain, bin}, 0);
    chk("reset_ready_turn", {bus.move_ready, turn, game_over}, 3'b100);
    rst_n = 1'b1;

    // Row 0-2 for A.
    play(0); play(3); play(1); play(4); play(2);
    chk("t1_ain", ain, 9'h007);
    chk("t1_winner", {game_over, winner}, 3'b101);
    chk("t1_wlq", win_line_q, 8'h04);
    chk("t1_cnt", move_cnt, 5);

    // B completes row 0-2 on the sixth move; later requests ignored.
    drive(1, 0, 0);
    play(4); play(0); play(8); play(2); play(6);
    chk("t2_no_win", game_over, 0);
    play(1);
    chk("t2_winner", {game_over, winner}, 3'b110);
    chk("t2_wlq_bit2", win_line_q[2], 1);
    drive(0, 1, 5); drive(0, 1, 7);
    chk("t2_ignored", {illegal, move_cnt}, 5'd6);

    // Full board with no line.
    drive(1, 0, 0);
    play(4); play(0); play(2); play(6); play(3); play(5); play(1); play(7); play(8);
    chk("t3_draw", {game_over, winner}, 3'b111);
    chk("t3_cnt", move_cnt, 9);
    chk("t3_wlq", win_line_q, 0);

    // Occupied cell and off-board index, then a legal move.
    drive(1, 0, 0);
    play(4);
    drive(0, 1, 4);
    chk("t4_ill_occupied", {illegal, turn, bin}, {1'b1, 1'b1, 9'h000});
    drive(0, 0, 0);
    chk("t4_ill_one_cycle", illegal, 0);
    drive(0, 1, 9);
    chk("t4_ill_range", {illegal, turn, bin}, {1'b1, 1'b1, 9'h000});
    play(5);
    chk("t4_accept", {bin, turn}, {9'h020, 1'b0});

    // A idles through its whole turn budget.
    drive(1, 0, 0);
    repeat (TMO - 1) drive(0, 0, 0);
    chk("t5_not_yet", game_over, 0);
    drive(0, 0, 0);
    chk("t5_forfeit", {game_over, winner, win_line_q}, {1'b1, 2'b10, 8'h00});

    // new_game beats a concurrent legal move; async reset during CHECK.
    drive(1, 0, 0);
    play(0);
    drive(1, 1, 3);
    chk("t6_newgame_move", {ain, bin, move_cnt}, 0);
    chk("t6_newgame_turn", {bus.move_ready, turn}, 2'b10);
    drive(0, 1, 4);
    pulse_reset();
    chk("t6_reset_check", {ain, bin, move_cnt, game_over}, 0);
    chk("t6_reset_turn", {bus.move_ready, turn}, 2'b10);

    // Random play, restarts and resets.
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 4) begin
        pulse_reset();
      end else begin
        ng  = (r < 25);
        mv  = ($urandom_range(0, 99) < 60);
        pos = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
        drive(ng, mv, pos);
      end
    end

    repeat (3) drive(0, 0, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
